// File: rtl/prior_code_fifo.sv
// Turns each new priority-encoder request into a one-shot event and queues it
// in a small first-word-fallthrough FIFO with a valid/ready output handshake.
module prior_code_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CODE_W-1:0]          in_code,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic [CODE_W-1:0]          out_code,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CODE_W-1:0] out_code_q, out_code_d;
    logic [CODE_W-1:0] prev_code_q, prev_code_d;
    logic              prev_valid_q, prev_valid_d;
    logic              overflow_q, overflow_d;
    logic              event_s;
    logic              pop_s;
    logic              push_s;
    logic              full_s;
    logic              nonempty_s;

    // Event detection, push/pop arbitration and next-state computation.
    always_comb begin
        full_s       = (count_q == FULL_CNT);
        nonempty_s   = (count_q != {CNT_W{1'b0}});
        event_s      = in_valid & (~prev_valid_q | (in_code != prev_code_q));
        pop_s        = nonempty_s & out_ready;
        // A pop frees the slot being written, so a full FIFO can still accept.
        push_s       = event_s & (~full_s | pop_s);
        prev_valid_d = in_valid;
        prev_code_d  = in_code;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        out_code_d   = out_code_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = in_code;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (event_s & ~push_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head is registered from next-state so outputs never see in_* combinationally.
        if (count_d != {CNT_W{1'b0}}) begin
            out_code_d = mem_d[rd_ptr_d];
        end else begin
            out_code_d = out_code_q;
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q        <= '{default: {CODE_W{1'b0}}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            out_code_q   <= {CODE_W{1'b0}};
            prev_code_q  <= {CODE_W{1'b0}};
            prev_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_code_q   <= out_code_d;
            prev_code_q  <= prev_code_d;
            prev_valid_q <= prev_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_code  = out_code_q;
    assign out_valid = nonempty_s;
    assign count     = count_q;
    assign full      = full_s;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_prior_code_fifo.sv
// Scenario-driven bench for prior_code_fifo; expected codes are queued as
// events are driven and compared as the FIFO presents them.
module tb_prior_code_fifo;
    logic       clk;
    logic       rst;
    logic [1:0] in_code;
    logic       in_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_valid;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int n_cmp;
    int n_err;
    logic [1:0] sb_q [$];

    prior_code_fifo #(.DEPTH(4), .CODE_W(2)) dut (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid),
        .out_ready(out_ready), .out_code(out_code), .out_valid(out_valid),
        .count(count), .full(full), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_code = 2'd3; out_ready = 1'b0;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b0;
        n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (full !== 1'b0)      begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_cmp++; if (out_code !== 2'd0)  begin n_err++; $display("FAIL reset_out_code got %0d exp 0", out_code); end
        tick();
    endtask

    task automatic test_held();
        logic [1:0] exp;
        in_valid = 1'b1; in_code = 2'd2; sb_q.push_back(2'd2);
        tick();
        n_cmp++; if (count !== 3'd1)    begin n_err++; $display("FAIL held_first_count got %0d exp 1", count); end
        n_cmp++; if (out_code !== 2'd2) begin n_err++; $display("FAIL held_first_code got %0d exp 2", out_code); end
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd1)    begin n_err++; $display("FAIL held_single_event got %0d exp 1", count); end
        out_ready = 1'b1;
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1 || out_code !== exp) begin n_err++; $display("FAIL held_pop got v=%b c=%0d exp v=1 c=%0d", out_valid, out_code, exp); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL held_drained got %0d exp 0", count); end
    endtask

    task automatic test_sequence();
        logic [1:0] codes [6];
        logic       vals  [6];
        logic [1:0] exp;
        codes = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1};
        vals  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        sb_q.push_back(2'd1); sb_q.push_back(2'd3); sb_q.push_back(2'd1);
        for (int i = 0; i < 6; i++) begin
            in_code = codes[i]; in_valid = vals[i];
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd3)    begin n_err++; $display("FAIL seq_count got %0d exp 3", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL seq_overflow got %b exp 0", overflow); end
        out_ready = 1'b1;
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1 || out_code !== exp) begin n_err++; $display("FAIL seq_pop got v=%b c=%0d exp v=1 c=%0d", out_valid, out_code, exp); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL seq_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [1:0] exp;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_code  = (i % 2 == 0) ? 2'd0 : 2'd3;
            if (i < 4) sb_q.push_back(in_code);
            tick();
            in_valid = 1'b0;
            tick();
        end
        n_cmp++; if (count !== 3'd4)    begin n_err++; $display("FAIL ovf_count got %0d exp 4", count); end
        n_cmp++; if (full !== 1'b1)     begin n_err++; $display("FAIL ovf_full got %b exp 1", full); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        out_ready = 1'b1;
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1 || out_code !== exp) begin n_err++; $display("FAIL ovf_pop got v=%b c=%0d exp v=1 c=%0d", out_valid, out_code, exp); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [1:0] exp;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_code = 2'(i); sb_q.push_back(2'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fpp_full got %b exp 1", full); end
        exp = sb_q.pop_front();
        n_cmp++; if (out_code !== exp) begin n_err++; $display("FAIL fpp_head got %0d exp %0d", out_code, exp); end
        out_ready = 1'b1; in_valid = 1'b1; in_code = 2'd2; sb_q.push_back(2'd2);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp++; if (count !== 3'd4)    begin n_err++; $display("FAIL fpp_count got %0d exp 4", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow got %b exp 0", overflow); end
        out_ready = 1'b1;
        while (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1 || out_code !== exp) begin n_err++; $display("FAIL fpp_pop got v=%b c=%0d exp v=1 c=%0d", out_valid, out_code, exp); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; in_code = 2'd1; tick();
        in_code = 2'd2; tick();
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL mrst_pre_count got %0d exp 2", count); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL mrst_count got %0d exp 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL mrst_overflow got %b exp 0", overflow); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd1)    begin n_err++; $display("FAIL mrst_repush_count got %0d exp 1", count); end
        n_cmp++; if (out_code !== 2'd2) begin n_err++; $display("FAIL mrst_repush_code got %0d exp 2", out_code); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = 2'd1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_code !== 2'd1) begin n_err++; $display("FAIL pass_out got v=%b c=%0d exp v=1 c=1", out_valid, out_code); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pass_one_cycle got %b exp 0", out_valid); end
        n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL pass_count got %0d exp 0", count); end
        tick();
        n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL pass_no_underflow got %0d exp 0", count); end
        n_cmp++; if (out_code !== 2'd1)  begin n_err++; $display("FAIL pass_code_hold got %0d exp 1", out_code); end
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_code = 2'd0; out_ready = 1'b0;
        test_reset();
        test_held();
        test_sequence();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
